mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter wordSize, default 4, data word width in bits.
REQ-002 SHALL have parameter numWords, default 64, number of stored words.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req0/req1  input  1 each  access request from requester 0/1.
REQ-006 SHALL have ports rw0/rw1  input  1 each  1 = read, 0 = write.
REQ-007 SHALL have ports addr0/addr1  input  $clog2(numWords) each  word address.
REQ-008 SHALL have ports data0/data1  input  wordSize each  write data.
REQ-009 SHALL have port grant  output  2  one-hot owner of the current access; 0 when idle.
REQ-010 SHALL have port done  output  2  one-cycle completion pulse to the owning requester.
REQ-011 SHALL have port dataOut  output  wordSize  read data, valid while done is high after a read.
REQ-012 SHALL have port parityErr  output  1  parity mismatch flag for the completed read.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS, DONE; IDLE->ACCESS on any sampled req, ACCESS->DONE unconditionally, DONE->IDLE unconditionally.
REQ-014 SHALL, in IDLE with a request pending, latch the winner's rw/addr/data at the edge and set grant to that port.
REQ-015 SHALL perform the memory read or write at the edge ending the ACCESS cycle using only the latched command.
REQ-016 SHALL pulse done[owner] for exactly the DONE cycle; grant is held through ACCESS and DONE, cleared on return to IDLE.
REQ-017 SHALL give a latency of 3 cycles from req sampled in IDLE to done high; throughput of one access per 3 cycles.
REQ-018 SHALL ignore req in ACCESS and DONE; a requester holding req after done is re-arbitrated in the next IDLE.
REQ-019 SHALL arbitrate round-robin: a lone request wins; on simultaneous requests the port not granted last wins.
REQ-020 SHALL hold dataOut at its last read value across writes and idle cycles.
REQ-021 SHALL treat addr >= numWords as out of range: write discarded, read returns all zeros, done still pulsed.
REQ-022 SHALL require requesters to hold command inputs stable only until the IDLE sampling edge.

Reset
REQ-023 SHALL, while reset is high, force state IDLE, grant 0, done 0, dataOut 0, parityErr 0, last-granted pointer = port 1.
REQ-024 SHALL abort an in-flight access on reset; a write whose ACCESS-ending edge coincides with or follows reset assertion SHALL NOT commit.
REQ-025 SHALL NOT reset memory contents.

Configuration
REQ-026 SHALL, with MEM_ARBITER_PARITY_EN defined, store one even-parity bit per word on write and set parityErr in DONE when a read's stored parity mismatches.
REQ-027 SHALL, without MEM_ARBITER_PARITY_EN, store wordSize bits per word and tie parityErr to 0.

Structure
REQ-028 SHALL place the FSM state encoding and port index constants in shared package mem_arbiter_pkg.
REQ-029 SHALL instantiate one sub-module mem_sync_ram (clocked single-port array, width wordSize or wordSize+1).

Verification
REQ-030 SHALL cover: after reset, req0=1 rw0=0 addr0=5 data0=4'hA, then req0 read addr 5 -> done[0] 3 cycles after each request, dataOut=4'hA.
REQ-031 SHALL cover: req0 and req1 both held high from reset release -> grants alternate port0, port1, port0, port1.
REQ-032 SHALL cover: req1 asserted during port0 ACCESS -> port1 granted only in the IDLE after port0's DONE.
REQ-033 SHALL cover: reset pulsed during ACCESS of write addr 3 data 4'h7 (prior 4'h2) -> later read of addr 3 returns 4'h2, grant and done 0 during reset.
REQ-034 SHALL cover: numWords=48, write addr 50 then read addr 50 -> done pulses, dataOut=0, addr 0-47 contents unchanged.
REQ-035 SHALL cover: with MEM_ARBITER_PARITY_EN, stored parity bit of addr 9 forced flipped -> read addr 9 gives parityErr=1 in DONE; without the macro parityErr stays 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding and port indices.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // One-hot grant/done vector for a port index.
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_sync_ram.sv
// Single-port word array: synchronous write, combinational read, no reset of contents.
module mem_sync_ram #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; commands outside the array are dropped.
  always_ff @(posedge clk) begin
    if (we && (32'(addr) < DEPTH)) begin
      mem[addr] <= wdata;
    end
  end

  // Read port; out-of-range addresses read as zero.
  always_comb begin
    rdata = '0;
    if (32'(addr) < DEPTH) begin
      rdata = mem[addr];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter in front of a single-port memory, one access per 3 cycles.
// Optional per-word even parity: define MEM_ARBITER_PARITY_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned wordSize = 4,
  parameter int unsigned numWords = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req0,
  input  logic                        req1,
  input  logic                        rw0,
  input  logic                        rw1,
  input  logic [$clog2(numWords)-1:0] addr0,
  input  logic [$clog2(numWords)-1:0] addr1,
  input  logic [wordSize-1:0]         data0,
  input  logic [wordSize-1:0]         data1,
  output logic [1:0]                  grant,
  output logic [1:0]                  done,
  output logic [wordSize-1:0]         dataOut,
  output logic                        parityErr
);

  localparam int unsigned AW = $clog2(numWords);
`ifdef MEM_ARBITER_PARITY_EN
  localparam int unsigned MW = wordSize + 1;
`else
  localparam int unsigned MW = wordSize;
`endif

  state_t                state;
  state_t                state_next;
  logic                  any_req;
  logic                  win;
  logic                  owner;
  logic                  last;
  logic                  cmd_rw;
  logic [AW-1:0]         cmd_addr;
  logic [wordSize-1:0]   cmd_data;
  logic                  in_range;
  logic                  ram_we;
  logic [MW-1:0]         ram_wdata;
  logic [MW-1:0]         ram_rdata;
  logic [1:0]            grant_next;
  logic [1:0]            done_next;
  logic                  perr_c;

  assign any_req  = req0 | req1;
  // A lone request wins; on a tie the port not granted last wins.
  assign win      = (req0 && req1) ? ~last : req1;
  assign in_range = 32'(cmd_addr) < numWords;
  // Reset gating keeps a write from committing on an edge where reset is already high.
  assign ram_we   = (state == ST_ACCESS) && !cmd_rw && in_range && !reset;

`ifdef MEM_ARBITER_PARITY_EN
  assign ram_wdata = {^cmd_data, cmd_data};
  assign perr_c    = in_range && (ram_rdata[wordSize] != ^ram_rdata[wordSize-1:0]);
`else
  assign ram_wdata = cmd_data;
  assign perr_c    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic: requests only matter in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (any_req) state_next = ST_ACCESS;
      ST_ACCESS: state_next = ST_DONE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output decode: next values of grant and done.
  always_comb begin
    grant_next = 2'b00;
    done_next  = 2'b00;
    case (state)
      ST_IDLE:   if (any_req) grant_next = port_onehot(win);
      ST_ACCESS: begin
        grant_next = grant;
        done_next  = port_onehot(owner);
      end
      default:   ;
    endcase
  end

  // Registered grant and done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant <= 2'b00;
      done  <= 2'b00;
    end else begin
      grant <= grant_next;
      done  <= done_next;
    end
  end

  // Command latch at arbitration, read-data capture at the end of ACCESS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last      <= PORT1;
      owner     <= PORT0;
      cmd_rw    <= 1'b1;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      dataOut   <= '0;
      parityErr <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (any_req) begin
          owner    <= win;
          last     <= win;
          cmd_rw   <= win ? rw1 : rw0;
          cmd_addr <= win ? addr1 : addr0;
          cmd_data <= win ? data1 : data0;
        end
        ST_ACCESS: if (cmd_rw) begin
          dataOut   <= in_range ? ram_rdata[wordSize-1:0] : '0;
          parityErr <= perr_c;
        end
        default: parityErr <= 1'b0;
      endcase
    end
  end

  mem_sync_ram #(
    .WIDTH (MW),
    .DEPTH (numWords),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (cmd_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random transactions against a
// transaction-level model (round-robin owner, word array, held read data).
module tb_mem_arbiter;

  localparam int unsigned WS = 4;
  localparam int unsigned NW = 48;
  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, rw0, rw1;
  logic [AW-1:0] addr0, addr1;
  logic [WS-1:0] data0, data1;
  logic [1:0]    grant, done;
  logic [WS-1:0] dataOut;
  logic          parityErr;

  int checks   = 0;
  int failures = 0;

  // Model state.
  int mem_m [NW];
  bit last_m;
  int exp_dout;

  always #5 clk = ~clk;

  mem_arbiter #(.wordSize(WS), .numWords(NW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .rw0       (rw0),
    .rw1       (rw1),
    .addr0     (addr0),
    .addr1     (addr1),
    .data0     (data0),
    .data1     (data1),
    .grant     (grant),
    .done      (done),
    .dataOut   (dataOut),
    .parityErr (parityErr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh(input bit p);
    return p ? 2'b10 : 2'b01;
  endfunction

  // One full transaction from an idle start; called right after a falling edge.
  task automatic do_txn(input bit r0, input bit r1, input bit c0rw, input bit c1rw,
                        input int a0, input int a1, input int d0, input int d1,
                        input bit pe);
    bit win, rw;
    int a, d;
    req0 = r0; req1 = r1; rw0 = c0rw; rw1 = c1rw;
    addr0 = AW'(a0); addr1 = AW'(a1); data0 = WS'(d0); data1 = WS'(d1);
    win = (r0 && r1) ? !last_m : r1;
    last_m = win;
    rw = win ? c1rw : c0rw;
    a  = win ? a1 : a0;
    d  = win ? d1 : d0;
    @(posedge clk); #1;
    check("grant_access", 32'(grant), 32'(oh(win)));
    check("done_access", 32'(done), 32'd0);
    // Command inputs need only be stable up to the sampling edge.
    req0 = 1'b0; req1 = 1'b0;
    rw0 = 1'($urandom); rw1 = 1'($urandom);
    addr0 = AW'($urandom); addr1 = AW'($urandom);
    data0 = WS'($urandom); data1 = WS'($urandom);
    @(posedge clk); #1;
    if (rw) exp_dout = (a < int'(NW)) ? mem_m[a] : 0;
    else if (a < int'(NW)) mem_m[a] = d;
    check("grant_done", 32'(grant), 32'(oh(win)));
    check("done_pulse", 32'(done), 32'(oh(win)));
    check("dataout", 32'(dataOut), 32'(exp_dout));
    check("parity_err", 32'(parityErr), 32'(pe));
    @(posedge clk); #1;
    check("grant_idle", 32'(grant), 32'd0);
    check("done_idle", 32'(done), 32'd0);
    check("dataout_hold", 32'(dataOut), 32'(exp_dout));
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dataout", 32'(dataOut), 32'd0);
    check("rst_parity", 32'(parityErr), 32'd0);
    reset = 1'b0;
    last_m = 1'b1;
    exp_dout = 0;
  endtask

  initial begin
    reset = 1'b1;
    req0 = 0; req1 = 0; rw0 = 1; rw1 = 1;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    for (int i = 0; i < int'(NW); i++) mem_m[i] = 0;
    apply_reset();

    // Write then read back through port 0.
    do_txn(1, 0, 0, 1, 5, 0, 'hA, 0, 0);
    do_txn(1, 0, 1, 1, 5, 0, 0, 0, 0);
    check("rd_addr5", 32'(dataOut), 32'hA);

    // Reset in the middle of a write's ACCESS cycle: the write must not land.
    do_txn(1, 0, 0, 1, 3, 0, 'h2, 0, 0);
    req0 = 1; rw0 = 0; addr0 = AW'(3); data0 = WS'(7);
    @(posedge clk); #3;
    reset = 1'b1;
    req0 = 1'b0;
    #1;
    check("rst_mid_grant", 32'(grant), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("rst_mid_grant2", 32'(grant), 32'd0);
    check("rst_mid_dout", 32'(dataOut), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    last_m = 1'b1;
    exp_dout = 0;
    do_txn(1, 0, 1, 1, 3, 0, 0, 0, 0);
    check("rd_addr3_kept", 32'(dataOut), 32'h2);

    // Fill the whole array through alternating ports.
    for (int i = 0; i < int'(NW); i++) begin
      if (i % 2 == 0) do_txn(1, 0, 0, 1, i, 0, int'($urandom_range(15)), 0, 0);
      else            do_txn(0, 1, 1, 0, 0, i, 0, int'($urandom_range(15)), 0);
    end

    // Request from port 1 during port 0's ACCESS waits for the next IDLE.
    req0 = 1; rw0 = 1; addr0 = AW'(10); req1 = 0;
    @(posedge clk); #1;
    check("late_grant0", 32'(grant), 32'b01);
    req0 = 0; req1 = 1; rw1 = 1; addr1 = AW'(11);
    @(posedge clk); #1;
    check("late_done0", 32'(done), 32'b01);
    check("late_grant0_hold", 32'(grant), 32'b01);
    check("late_dout0", 32'(dataOut), 32'(mem_m[10]));
    @(posedge clk); #1;
    check("late_idle", 32'(grant), 32'd0);
    @(posedge clk); #1;
    check("late_grant1", 32'(grant), 32'b10);
    req1 = 0;
    @(posedge clk); #1;
    check("late_done1", 32'(done), 32'b10);
    check("late_dout1", 32'(dataOut), 32'(mem_m[11]));
    @(posedge clk); #1;
    check("late_idle2", 32'(grant), 32'd0);
    @(negedge clk);
    last_m = 1'b1;
    exp_dout = mem_m[11];

    // Out-of-range address: write dropped, read returns zero, done still pulses.
    do_txn(1, 0, 0, 1, 50, 0, 'hF, 0, 0);
    do_txn(0, 1, 1, 1, 0, 50, 0, 0, 0);
    check("oor_read_zero", 32'(dataOut), 32'd0);

    // Parity on address 9.
`ifdef MEM_ARBITER_PARITY_EN
    do_txn(1, 0, 0, 1, 9, 0, 'h6, 0, 0);
    dut.u_ram.mem[9][WS] = ~dut.u_ram.mem[9][WS];
    do_txn(1, 0, 1, 1, 9, 0, 0, 0, 1);
    do_txn(1, 0, 0, 1, 9, 0, 'h6, 0, 0);
`else
    do_txn(1, 0, 1, 1, 9, 0, 0, 0, 0);
`endif

    // Both requests held from reset release: ownership alternates every 3 cycles.
    reset = 1'b1;
    @(negedge clk);
    req0 = 1; req1 = 1; rw0 = 1; rw1 = 1; addr0 = '0; addr1 = '0;
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      int ph, own;
      @(posedge clk); #1;
      ph  = k % 3;
      own = (k / 3) % 2;
      check("held_grant", 32'(grant), (ph < 2) ? 32'(oh(own[0])) : 32'd0);
      check("held_done", 32'(done), (ph == 1) ? 32'(oh(own[0])) : 32'd0);
    end
    req0 = 0; req1 = 0;
    @(negedge clk);
    last_m = 1'b1;
    exp_dout = mem_m[0];

    // Random transactions with idle gaps; addresses include out-of-range ones.
    for (int n = 0; n < 150; n++) begin
      bit r0, r1;
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      do_txn(r0, r1, 1'($urandom), 1'($urandom),
             int'($urandom_range(63)), int'($urandom_range(63)),
             int'($urandom_range(15)), int'($urandom_range(15)), 0);
      repeat ($urandom_range(2)) @(negedge clk);
    end

    // Final sweep: every in-range word matches the model.
    for (int i = 0; i < int'(NW); i++) begin
      do_txn(0, 1, 1, 1, 0, i, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
